mvu_result_reader: RTL and testbench



---
 rtl/mvu_pkg.sv | 19 +
 rtl/barvinn_sync_fifo.sv | 64 ++++++
 rtl/mvu_result_reader.sv | 217 +++++++++++++++++++++
 tb/tb_mvu_result_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared MVU constants and types.
//   BDBANKA   : result-RAM address width
//   BDBANKW   : result-RAM word width
//   RR_LEN_W  : width of the result-reader block length
//   rr_state_t: result-reader control states
package mvu_pkg;

  localparam int unsigned BDBANKA  = 15;
  localparam int unsigned BDBANKW  = 64;
  localparam int unsigned RR_LEN_W = BDBANKA + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rr_state_t;

endpackage

// File: rtl/barvinn_sync_fifo.sv
// Synchronous FIFO with registered empty/full flags and an occupancy count.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write strobe and data
//   pop/rdata  : read strobe; rdata shows the head entry while non-empty
//   empty/full : status flags
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of 2 so the pointers wrap naturally.
module barvinn_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nx;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

  always_comb begin
    count_nx = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nx;
      empty <= (count_nx == '0);
      full  <= (count_nx == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/mvu_result_reader.sv
// Result-RAM read-back engine: reads len words starting at baddr over the
// rdc_* port and streams each word out as DATA_W/XLEN XLEN-bit slices,
// least-significant first. Requests are credit-limited against the
// read-data FIFO so output backpressure never drops returned data.
//   clk, rst_n        : clock, async active-low reset
//   start, baddr, len : command (accepted only in idle)
//   busy, done        : transfer in progress / one-cycle completion pulse
//   rdc_en, rdc_addr  : read request (address held until granted)
//   rdc_grnt          : request accepted when high with rdc_en
//   rdc_word          : read data, RD_LAT cycles after acceptance
//   o_valid, o_ready, o_word : output stream
module mvu_result_reader
  import mvu_pkg::*;
#(
  parameter int unsigned ADDR_W     = BDBANKA,
  parameter int unsigned DATA_W     = BDBANKW,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] baddr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rdc_en,
  output logic [ADDR_W-1:0] rdc_addr,
  input  logic              rdc_grnt,
  input  logic [DATA_W-1:0] rdc_word,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [XLEN-1:0]   o_word
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned NSLICE = DATA_W / XLEN;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  rr_state_t state;
  rr_state_t state_nx;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  remaining_nx;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  ret_cnt;
  logic [RD_LAT-1:0] pipe_v;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_nx;
  logic [CNT_W-1:0]  occ_nx;
  logic [CNT_W:0]    credit_nx;

  logic              start_acc;
  logic              accept;
  logic              pipe_out;
  logic              hs;
  logic              last_slice;
  logic              ser_free;
  logic              bypass;
  logic              ser_load;
  logic [DATA_W-1:0] load_word;
  logic              rdc_en_nx;
  logic              busy_nx;
  logic              done_nx;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  logic              ser_full;
  logic [DATA_W-1:0] ser_sh;
  logic [IDX_W-1:0]  idx;

  assign rdc_addr = addr;
  assign o_valid  = ser_full;
  assign o_word   = ser_sh[XLEN-1:0];

  barvinn_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (rdc_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Handshakes, serializer refill and credit bookkeeping.
  // A returning word goes straight into an idle serializer when the FIFO
  // is empty, which saves a cycle on the first word of every burst.
  always_comb begin
    start_acc    = start && (state == IDLE);
    accept       = rdc_en && rdc_grnt;
    pipe_out     = pipe_v[RD_LAT-1];
    hs           = ser_full && o_ready;
    last_slice   = (idx == IDX_W'(NSLICE - 1));
    ser_free     = !ser_full || (hs && last_slice);
    fifo_pop     = ser_free && !fifo_empty;
    bypass       = ser_free && fifo_empty && pipe_out;
    fifo_push    = pipe_out && !bypass;
    ser_load     = fifo_pop || bypass;
    load_word    = fifo_pop ? fifo_rdata : rdc_word;
    remaining_nx = start_acc ? len : (remaining - LEN_W'(accept));
    inflight_nx  = start_acc ? '0 : (inflight + CNT_W'(accept) - CNT_W'(pipe_out));
    occ_nx       = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    credit_nx    = (CNT_W+1)'(inflight_nx) + (CNT_W+1)'(occ_nx);
  end

  // Next state plus next values of the registered control outputs.
  always_comb begin
    state_nx  = state;
    rdc_en_nx = 1'b0;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (accept && (remaining == LEN_W'(1))) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // All data returned, nothing buffered, last slice leaving now.
        if ((ret_cnt == len_q) && fifo_empty && ser_free) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    rdc_en_nx = (state_nx == RUN) && (remaining_nx != '0) &&
                (credit_nx < (CNT_W+1)'(FIFO_DEPTH));
    busy_nx   = (state_nx == RUN) || (state_nx == DRAIN);
    done_nx   = (state_nx == FIN);
  end

  // Control, request and return-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      len_q     <= '0;
      ret_cnt   <= '0;
      pipe_v    <= '0;
      inflight  <= '0;
      rdc_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      inflight  <= inflight_nx;
      rdc_en    <= rdc_en_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      if (start_acc) begin
        addr    <= baddr;
        len_q   <= len;
        ret_cnt <= '0;
        pipe_v  <= '0;
      end else begin
        if (accept) begin
          addr <= addr + ADDR_W'(1);
        end
        if (pipe_out) begin
          ret_cnt <= ret_cnt + LEN_W'(1);
        end
        pipe_v <= (pipe_v << 1) | RD_LAT'(accept);
      end
    end
  end

  // Serializer: a shift register so o_word is always its low slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_full <= 1'b0;
      ser_sh   <= '0;
      idx      <= '0;
    end else if (ser_load) begin
      ser_full <= 1'b1;
      ser_sh   <= load_word;
      idx      <= '0;
    end else if (hs) begin
      if (last_slice) begin
        ser_full <= 1'b0;
      end else begin
        ser_sh <= ser_sh >> XLEN;
        idx    <= idx + IDX_W'(1);
      end
    end
  end

  // The credit rule must keep the FIFO from ever overflowing.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_mvu_result_reader.sv
// Self-checking bench for mvu_result_reader: a RAM model answers read
// requests, a queue-based reference model predicts request addresses and the
// output stream, and directed tests pin timing with literal expectations.
module tb_mvu_result_reader;

  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NSLICE     = DATA_W / XLEN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] baddr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              rdc_en;
  logic [ADDR_W-1:0] rdc_addr;
  logic              rdc_grnt;
  logic [DATA_W-1:0] rdc_word;
  logic              o_valid;
  logic              o_ready;
  logic [XLEN-1:0]   o_word;

  mvu_result_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .XLEN       (XLEN),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .baddr    (baddr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rdc_en   (rdc_en),
    .rdc_addr (rdc_addr),
    .rdc_grnt (rdc_grnt),
    .rdc_word (rdc_word),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_word   (o_word)
  );

  always #5 clk = ~clk;

  // RAM content: low half 0x5555_0000|addr, high half 0xAAAA_0000|addr.
  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return {16'hAAAA, 1'b0, a, 16'h5555, 1'b0, a};
  endfunction

  // RAM read port with RD_LAT latency.
  logic [RD_LAT-1:0] rq_v;
  logic [ADDR_W-1:0] rq_a [RD_LAT];
  always @(posedge clk) begin
    rq_v    <= (rq_v << 1) | RD_LAT'(rdc_en && rdc_grnt);
    rq_a[0] <= rdc_addr;
    for (int i = 1; i < int'(RD_LAT); i++) rq_a[i] <= rq_a[i-1];
  end
  assign rdc_word = rq_v[RD_LAT-1] ? ram_word(rq_a[RD_LAT-1]) : 64'hDEAD_BEEF_DEAD_BEEF;

  int n_pass = 0;
  int n_total = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // Reference model state.
  logic [XLEN-1:0]   exp_q[$];
  logic [ADDR_W-1:0] req_q[$];
  logic [ADDR_W-1:0] req_log[$];
  bit                done_due, busy_exp, prev_en_stall, prev_out_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [XLEN-1:0]   prev_word;
  logic [XLEN-1:0]   first_out_word;
  int outstanding, slice_ct, n_req, n_out, n_done;
  int start_cyc, first_valid_cyc, done_cyc;

  // Compare process: all outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset done", 64'(done), 64'(0));
      chk("reset rdc_en", 64'(rdc_en), 64'(0));
      chk("reset rdc_addr", 64'(rdc_addr), 64'(0));
      chk("reset o_valid", 64'(o_valid), 64'(0));
      chk("reset o_word", 64'(o_word), 64'(0));
      exp_q.delete();
      req_q.delete();
      done_due = 0; busy_exp = 0; prev_en_stall = 0; prev_out_stall = 0;
      outstanding = 0; slice_ct = 0;
    end else begin
      chk("done", 64'(done), 64'(done_due));
      chk("busy", 64'(busy), 64'(busy_exp));
      done_due = 0;
      if (done) begin
        n_done++;
        done_cyc = cyc_n;
      end
      // Requests.
      if (prev_en_stall)
        chk("rdc_addr hold", 64'({rdc_en, rdc_addr}), 64'({1'b1, prev_addr}));
      if (rdc_en && req_q.size() == 0) begin
        chk("extra rdc_en", 64'(rdc_en), 64'(0));
      end else if (rdc_en && rdc_grnt) begin
        chk("rdc_addr", 64'(rdc_addr), 64'(req_q[0]));
        void'(req_q.pop_front());
        req_log.push_back(rdc_addr);
        n_req++;
        outstanding++;
      end
      prev_en_stall = rdc_en && !rdc_grnt;
      prev_addr = rdc_addr;
      // Output stream.
      if (prev_out_stall)
        chk("o_word hold", 64'({o_valid, o_word}), 64'({1'b1, prev_word}));
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
      if (o_valid && exp_q.size() == 0) begin
        chk("extra o_valid", 64'(o_valid), 64'(0));
      end else if (o_valid && o_ready) begin
        chk("o_word", 64'(o_word), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        if (n_out == 0) first_out_word = o_word;
        n_out++;
        slice_ct++;
        if (slice_ct == int'(NSLICE)) begin
          slice_ct = 0;
          outstanding--;
        end
        if (exp_q.size() == 0) begin
          done_due = 1;
          busy_exp = 0;
        end
      end
      prev_out_stall = o_valid && !o_ready;
      prev_word = o_word;
      // Requested-but-unconsumed words: FIFO credit plus the serializer.
      chk("credit bound", 64'(outstanding <= int'(FIFO_DEPTH) + 1), 64'(1));
      // Command acceptance.
      if (start && !busy && !done) begin
        exp_q.delete();
        req_q.delete();
        req_log.delete();
        for (int i = 0; i < int'(len); i++) begin
          logic [ADDR_W-1:0] a;
          logic [DATA_W-1:0] w;
          a = ADDR_W'(int'(baddr) + i);
          w = ram_word(a);
          req_q.push_back(a);
          for (int s = 0; s < int'(NSLICE); s++) exp_q.push_back(XLEN'(w >> (s * int'(XLEN))));
        end
        n_req = 0; n_out = 0; n_done = 0; slice_ct = 0; outstanding = 0;
        start_cyc = cyc_n;
        first_valid_cyc = -1;
        done_cyc = -1;
        if (len == '0) done_due = 1;
        else busy_exp = 1;
      end
    end
  end

  // Stimulus controls.
  int gnt_mode = 0;
  int gnt_base = 0;
  int rdy_from = -100;
  int t_start = 0;

  task automatic cyc();
    int k;
    @(posedge clk);
    #1;
    cyc_n++;
    start = 1'b0;
    k = cyc_n - gnt_base;
    if (gnt_mode == 0) rdc_grnt = 1'b1;
    else rdc_grnt = (k >= 2) && (k % 2 == 0);
    o_ready = !(cyc_n >= rdy_from && cyc_n < rdy_from + 20);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l);
    cyc();
    baddr = a;
    len = l;
    start = 1'b1;
    t_start = cyc_n;
    gnt_base = cyc_n + 1;
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!done && k < 400);
    if (!done) chk("done timeout", 64'(done), 64'(1));
    cyc();
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; baddr = '0; len = '0;
    rdc_grnt = 1'b0; o_ready = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Basic read, no backpressure.
    do_start(15'h0010, 16'd3);
    wait_done();
    chk("basic first valid latency", 64'(first_valid_cyc - t_start), 64'(RD_LAT + 2));
    chk("basic done latency", 64'(done_cyc - t_start), 64'(10));
    chk("basic first word", 64'(first_out_word), 64'h5555_0010);
    chk("basic requests", 64'(n_req), 64'(3));
    chk("basic outputs", 64'(n_out), 64'(6));
    chk("basic done count", 64'(n_done), 64'(1));

    // Grant stalls 0,0,1,0,1...
    gnt_mode = 1;
    do_start(15'h0100, 16'd4);
    wait_done();
    gnt_mode = 0;
    chk("stall requests", 64'(n_req), 64'(4));
    chk("stall outputs", 64'(n_out), 64'(8));

    // Output backpressure for 20 cycles mid-transfer.
    rdy_from = cyc_n + 7;
    do_start(15'h0200, 16'd8);
    wait_done();
    rdy_from = -100;
    chk("bp outputs", 64'(n_out), 64'(16));
    chk("bp done count", 64'(n_done), 64'(1));

    // Address wrap.
    do_start(15'h7FFE, 16'd4);
    wait_done();
    chk("wrap request count", 64'(req_log.size()), 64'(4));
    if (req_log.size() >= 4) begin
      chk("wrap addr0", 64'(req_log[0]), 64'h7FFE);
      chk("wrap addr1", 64'(req_log[1]), 64'h7FFF);
      chk("wrap addr2", 64'(req_log[2]), 64'h0000);
      chk("wrap addr3", 64'(req_log[3]), 64'h0001);
    end

    // Zero-length command.
    do_start(15'h0300, 16'd0);
    wait_done();
    chk("len0 done latency", 64'(done_cyc - t_start), 64'(1));
    chk("len0 requests", 64'(n_req), 64'(0));

    // Start while busy is ignored.
    do_start(15'h0400, 16'd4);
    cyc(); cyc();
    baddr = 15'h0555; len = 16'd2; start = 1'b1;
    wait_done();
    chk("busy start outputs", 64'(n_out), 64'(8));
    chk("busy start done count", 64'(n_done), 64'(1));

    // Reset mid-transfer, then a fresh short transfer.
    do_start(15'h0500, 16'd8);
    begin
      int k = 0;
      do begin
        cyc();
        k++;
      end while (n_out < 3 && k < 100);
      chk("pre-reset outputs", 64'(n_out >= 3), 64'(1));
    end
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    do_start(15'h0040, 16'd2);
    wait_done();
    chk("post-reset outputs", 64'(n_out), 64'(4));
    chk("post-reset first word", 64'(first_out_word), 64'h5555_0040);
    chk("post-reset done count", 64'(n_done), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
